// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: requester / arbiter / downstream-sink bus bundle.
// master: arbiter side (drives grant and the serialized beat stream).
// slave:  requester and sink side (drives req, words and data_ready).
// Optional macro BUS_ARBITER_LOCK_EN adds the per-requester req_lock vector.
interface bus_arbiter_rr_if #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned ADDRW = 24,
   parameter int unsigned DW    = 8
);
   localparam int unsigned WORDW = ADDRW + 8;

   logic [NREQ-1:0]       req;
   logic [NREQ*WORDW-1:0] data_in;
   logic [NREQ-1:0]       grant;
   logic [DW-1:0]         data_out;
   logic                  data_valid;
   logic                  data_ready;
   logic                  data_last;

`ifdef BUS_ARBITER_LOCK_EN
   logic [NREQ-1:0]       req_lock;

   modport master (
      input  req, req_lock, data_in, data_ready,
      output grant, data_out, data_valid, data_last
   );

   modport slave (
      output req, req_lock, data_in, data_ready,
      input  grant, data_out, data_valid, data_last
   );
`else
   modport master (
      input  req, data_in, data_ready,
      output grant, data_out, data_valid, data_last
   );

   modport slave (
      output req, data_in, data_ready,
      input  grant, data_out, data_valid, data_last
   );
`endif

endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter over NREQ requesters that serializes the
// granted ADDRW+8 bit word onto a DW-bit valid/ready bus, LSB slice first.
// Optional macro BUS_ARBITER_LOCK_EN: a requester holding req_lock keeps the
// grant across consecutive words.
module bus_arbiter_rr #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned ADDRW = 24,
   parameter int unsigned DW    = 8
) (
   input logic              clk,
   input logic              rst_n,
   bus_arbiter_rr_if.master bus
);

   localparam int unsigned WORDW = ADDRW + 8;
   localparam int unsigned BEATS = WORDW / DW;
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned DIW   = $clog2(NREQ * WORDW);

   localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);
   localparam logic [IW-1:0] LastReq  = IW'(NREQ - 1);

   typedef enum logic {StIdle, StSend} state_e;

   state_e          state_q;
   logic [NREQ-1:0] grant_q;
   logic [IW-1:0]   gnt_idx_q;
   logic [IW-1:0]   last_idx_q;
   logic [BW-1:0]   beat_q;
   logic            valid_q;

   logic [IW-1:0]   arb_ptr;
   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [NREQ-1:0] win_onehot;
   int unsigned     cand;
   logic [IW-1:0]   cand_idx;

   logic            accept;
   logic            last_accept;
   logic            lock_keep;
   logic [DIW-1:0]  slice_base;
   logic [DW-1:0]   data_out_c;

   // Round-robin search starting after the pointer. While sending, the pointer is the
   // granted index, so a re-arbitration on the last beat ranks the current owner last.
   always_comb begin
      arb_ptr    = (state_q == StSend) ? gnt_idx_q : last_idx_q;
      win_found  = 1'b0;
      win_idx    = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = 32'(arb_ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IW'(cand);
         if (!win_found && bus.req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   // Handshake and burst-lock qualifiers for the current beat.
   always_comb begin
      accept      = valid_q && bus.data_ready;
      last_accept = accept && (beat_q == LastBeat);
`ifdef BUS_ARBITER_LOCK_EN
      lock_keep   = bus.req_lock[gnt_idx_q] && bus.req[gnt_idx_q];
`else
      lock_keep   = 1'b0;
`endif
   end

   // Arbitration / serialization FSM; grant, valid, beat and pointer are all registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         gnt_idx_q  <= '0;
         last_idx_q <= LastReq;
         beat_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  state_q   <= StSend;
                  grant_q   <= win_onehot;
                  gnt_idx_q <= win_idx;
                  beat_q    <= '0;
                  valid_q   <= 1'b1;
               end
            end
            StSend: begin
               if (accept && !last_accept) begin
                  beat_q <= beat_q + 1'b1;
               end else if (last_accept) begin
                  beat_q <= '0;
                  if (!lock_keep) begin
                     last_idx_q <= gnt_idx_q;
                     if (win_found) begin
                        // Back-to-back hand-over, no idle bubble.
                        grant_q   <= win_onehot;
                        gnt_idx_q <= win_idx;
                     end else begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Beat mux driven only by registered grant index and beat counter; zero when idle.
   always_comb begin
      slice_base = DIW'(32'(gnt_idx_q) * WORDW + 32'(beat_q) * DW);
      data_out_c = '0;
      if (valid_q) begin
         data_out_c = bus.data_in[slice_base +: DW];
      end
   end

   assign bus.grant      = grant_q;
   assign bus.data_valid = valid_q;
   assign bus.data_last  = valid_q && (beat_q == LastBeat);
   assign bus.data_out   = data_out_c;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scoreboard bench for bus_arbiter_rr in three configurations
// (2 x 8-bit beats, 4 requesters, 2 x 16-bit beats). Lock scenario runs only when
// BUS_ARBITER_LOCK_EN is defined.
module tb_bus_arbiter_rr;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bus_arbiter_rr_if #(.NREQ(2), .ADDRW(24), .DW(8))  bus2 ();
   bus_arbiter_rr_if #(.NREQ(4), .ADDRW(24), .DW(8))  bus4 ();
   bus_arbiter_rr_if #(.NREQ(2), .ADDRW(24), .DW(16)) bus16 ();

   bus_arbiter_rr #(.NREQ(2), .ADDRW(24), .DW(8)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   bus_arbiter_rr #(.NREQ(4), .ADDRW(24), .DW(8)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   bus_arbiter_rr #(.NREQ(2), .ADDRW(24), .DW(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   typedef struct packed {
      logic [3:0]  gnt;
      logic [15:0] data;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   // Expected beats of one word, LSB slice first.
   task automatic push_word(input logic [3:0] gnt, input logic [31:0] w, input int dw);
      int    nb;
      beat_t e;
      nb = 32 / dw;
      for (int b = 0; b < nb; b++) begin
         e.gnt  = gnt;
         e.data = 16'((w >> (b * dw)) & ((32'h1 << dw) - 1));
         e.last = (b == nb - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_idle();
      bus2.req = '0;  bus2.data_in = '0;  bus2.data_ready = 1'b1;
      bus4.req = '0;  bus4.data_in = '0;  bus4.data_ready = 1'b1;
      bus16.req = '0; bus16.data_in = '0; bus16.data_ready = 1'b1;
`ifdef BUS_ARBITER_LOCK_EN
      bus2.req_lock = '0; bus4.req_lock = '0; bus16.req_lock = '0;
`endif
   endtask

   task automatic do_reset();
      drive_idle();
      exp_q.delete();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus2.grant !== 2'b00 || bus2.data_valid !== 1'b0 || bus2.data_last !== 1'b0 ||
          bus2.data_out !== 8'h00)
         $display("FAIL reset_dut2: got gnt=%b v=%b l=%b d=%h want 00 0 0 00",
                  bus2.grant, bus2.data_valid, bus2.data_last, bus2.data_out);
      else n_pass++;
      n_checks++;
      if (bus4.grant !== 4'b0000 || bus4.data_valid !== 1'b0 || bus4.data_last !== 1'b0)
         $display("FAIL reset_dut4: got gnt=%b v=%b l=%b want 0000 0 0",
                  bus4.grant, bus4.data_valid, bus4.data_last);
      else n_pass++;
      // Requests during reset must not be granted.
      bus2.req = 2'b11;
      bus2.data_in = {32'h55667788, 32'h11223344};
      @(negedge clk);
      n_checks++;
      if (bus2.grant !== 2'b00 || bus2.data_valid !== 1'b0 || bus2.data_out !== 8'h00)
         $display("FAIL reset_hold_req: got gnt=%b v=%b d=%h want 00 0 00",
                  bus2.grant, bus2.data_valid, bus2.data_out);
      else n_pass++;
      drive_idle();
      rst_n = 1'b1;
   endtask

   task automatic test_single_word();
      beat_t e;
      int    n;
      do_reset();
      bus2.data_in = {32'h0, 32'hA1B2C3D4};
      bus2.req     = 2'b01;
      push_word(4'b0001, 32'hA1B2C3D4, 8);
      @(negedge clk);
      n_checks++;
      if (bus2.grant !== 2'b01 || bus2.data_valid !== 1'b1)
         $display("FAIL single_latency: got gnt=%b v=%b want 01 1", bus2.grant, bus2.data_valid);
      else n_pass++;
      bus2.req = 2'b00;  // dropping req mid-word must not cut the word short
      n = 0;
      for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (bus2.data_valid && bus2.data_ready) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus2.grant !== e.gnt[1:0] || bus2.data_out !== e.data[7:0] ||
                bus2.data_last !== e.last)
               $display("FAIL single_beat%0d: got gnt=%b d=%h l=%b want gnt=%b d=%h l=%b", n,
                        bus2.grant, bus2.data_out, bus2.data_last, e.gnt[1:0], e.data[7:0], e.last);
            else n_pass++;
            n++;
         end
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL single_timeout: got %0d beats left want 0", exp_q.size());
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus2.data_valid !== 1'b0 || bus2.grant !== 2'b00)
         $display("FAIL single_idle: got v=%b gnt=%b want 0 00", bus2.data_valid, bus2.grant);
      else n_pass++;
   endtask

   task automatic test_alternate();
      beat_t e;
      int    n, gaps;
      do_reset();
      bus2.data_in = {32'h55667788, 32'h11223344};
      bus2.req     = 2'b11;
      push_word(4'b0001, 32'h11223344, 8);
      push_word(4'b0010, 32'h55667788, 8);
      push_word(4'b0001, 32'h11223344, 8);
      n    = 0;
      gaps = 0;
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (bus2.data_valid && bus2.data_ready) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus2.grant !== e.gnt[1:0] || bus2.data_out !== e.data[7:0] ||
                bus2.data_last !== e.last)
               $display("FAIL alt_beat%0d: got gnt=%b d=%h l=%b want gnt=%b d=%h l=%b", n,
                        bus2.grant, bus2.data_out, bus2.data_last, e.gnt[1:0], e.data[7:0], e.last);
            else n_pass++;
            n++;
         end else if (n > 0) begin
            gaps++;
         end
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL alt_timeout: got %0d beats left want 0", exp_q.size());
      else n_pass++;
      n_checks++;
      if (gaps != 0) $display("FAIL alt_gap: got %0d idle cycles want 0", gaps);
      else n_pass++;
   endtask

   task automatic test_rr4();
      beat_t e;
      int    n;
      int    order[8] = '{0, 1, 2, 3, 0, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus4.data_in[i*32 +: 32] = 32'h10203040 + 32'h01010101 * i;
      end
      bus4.req = 4'b1111;
      for (int w = 0; w < 8; w++) begin
         push_word(4'b0001 << order[w], 32'h10203040 + 32'h01010101 * order[w], 8);
      end
      n = 0;
      for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (bus4.data_valid && bus4.data_ready) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus4.grant !== e.gnt || bus4.data_out !== e.data[7:0] || bus4.data_last !== e.last)
               $display("FAIL rr4_beat%0d: got gnt=%b d=%h l=%b want gnt=%b d=%h l=%b", n,
                        bus4.grant, bus4.data_out, bus4.data_last, e.gnt, e.data[7:0], e.last);
            else n_pass++;
            n++;
            if (n == 17) bus4.req = 4'b1101;  // requester 1 leaves during the 5th word
         end
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL rr4_timeout: got %0d beats left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_stall();
      beat_t      e;
      int         accepted;
      logic       pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] held_data;
      logic       held_last;
      do_reset();
      bus2.data_in    = {32'h0, 32'hA1B2C3D4};
      bus2.data_ready = 1'b0;
      bus2.req        = 2'b01;
      push_word(4'b0001, 32'hA1B2C3D4, 8);
      @(negedge clk);
      bus2.req  = 2'b00;
      accepted  = 0;
      held_data = '0;
      held_last = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         bus2.data_ready = pat[k];
         if (k > 0 && !pat[k-1]) begin
            n_checks++;
            if (bus2.data_out !== held_data || bus2.data_last !== held_last)
               $display("FAIL stall_hold%0d: got d=%h l=%b want d=%h l=%b", k,
                        bus2.data_out, bus2.data_last, held_data, held_last);
            else n_pass++;
         end
         if (bus2.data_valid && bus2.data_ready) begin
            accepted++;
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL stall_extra: got beat d=%h want none", bus2.data_out);
            end else begin
               e = exp_q.pop_front();
               if (bus2.grant !== e.gnt[1:0] || bus2.data_out !== e.data[7:0] ||
                   bus2.data_last !== e.last)
                  $display("FAIL stall_beat%0d: got gnt=%b d=%h l=%b want gnt=%b d=%h l=%b", k,
                           bus2.grant, bus2.data_out, bus2.data_last, e.gnt[1:0], e.data[7:0],
                           e.last);
               else n_pass++;
            end
         end
         held_data = bus2.data_out;
         held_last = bus2.data_last;
      end
      @(negedge clk);
      bus2.data_ready = 1'b1;
      n_checks++;
      if (accepted != 4) $display("FAIL stall_count: got %0d beats want 4", accepted);
      else n_pass++;
      n_checks++;
      if (bus2.data_valid !== 1'b0) $display("FAIL stall_idle: got v=%b want 0", bus2.data_valid);
      else n_pass++;
   endtask

   task automatic test_dw16_reset();
      beat_t e;
      int    n;
      do_reset();
      bus16.data_in = {32'h0BADF00D, 32'hA1B2C3D4};
      bus16.req     = 2'b01;
      push_word(4'b0001, 32'hA1B2C3D4, 16);
      n = 0;
      for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (bus16.data_valid && bus16.data_ready) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus16.grant !== e.gnt[1:0] || bus16.data_out !== e.data ||
                bus16.data_last !== e.last)
               $display("FAIL dw16_beat%0d: got gnt=%b d=%h l=%b want gnt=%b d=%h l=%b", n,
                        bus16.grant, bus16.data_out, bus16.data_last, e.gnt[1:0], e.data, e.last);
            else n_pass++;
            n++;
         end
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL dw16_timeout: got %0d beats left want 0", exp_q.size());
      else n_pass++;
      // req still high: same requester restarts; abort it on its second beat.
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus16.data_valid !== 1'b1 || bus16.data_out !== 16'hA1B2 || bus16.data_last !== 1'b1)
         $display("FAIL dw16_beat1: got v=%b d=%h l=%b want 1 a1b2 1",
                  bus16.data_valid, bus16.data_out, bus16.data_last);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus16.grant !== 2'b00 || bus16.data_valid !== 1'b0 || bus16.data_last !== 1'b0 ||
          bus16.data_out !== 16'h0000)
         $display("FAIL dw16_abort: got gnt=%b v=%b l=%b d=%h want 00 0 0 0000",
                  bus16.grant, bus16.data_valid, bus16.data_last, bus16.data_out);
      else n_pass++;
      bus16.req = 2'b11;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus16.grant !== 2'b01 || bus16.data_valid !== 1'b1 || bus16.data_out !== 16'hC3D4)
         $display("FAIL dw16_after_reset: got gnt=%b v=%b d=%h want 01 1 c3d4",
                  bus16.grant, bus16.data_valid, bus16.data_out);
      else n_pass++;
   endtask

`ifdef BUS_ARBITER_LOCK_EN
   task automatic test_lock();
      beat_t e;
      int    n;
      do_reset();
      bus2.data_in  = {32'h55667788, 32'h11223344};
      bus2.req      = 2'b11;
      bus2.req_lock = 2'b01;
      push_word(4'b0001, 32'h11223344, 8);
      push_word(4'b0001, 32'h11223344, 8);
      push_word(4'b0001, 32'h11223344, 8);
      push_word(4'b0010, 32'h55667788, 8);
      n = 0;
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (bus2.data_valid && bus2.data_ready) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus2.grant !== e.gnt[1:0] || bus2.data_out !== e.data[7:0] ||
                bus2.data_last !== e.last)
               $display("FAIL lock_beat%0d: got gnt=%b d=%h l=%b want gnt=%b d=%h l=%b", n,
                        bus2.grant, bus2.data_out, bus2.data_last, e.gnt[1:0], e.data[7:0], e.last);
            else n_pass++;
            n++;
            if (n == 9) bus2.req_lock = 2'b00;  // release during the third locked word
         end
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL lock_timeout: got %0d beats left want 0", exp_q.size());
      else n_pass++;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      drive_idle();
      test_reset();
      test_single_word();
      test_alternate();
      test_rr4();
      test_stall();
      test_dw16_reset();
`ifdef BUS_ARBITER_LOCK_EN
      test_lock();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised round-robin bus arbiter and word serializer. It sits between `NREQ` request FSMs (AES, SHA, future cores) and the shared narrow data bus. It grants one requester at a time, then streams that requester's `ADDRW+8`-bit word onto the bus LSB-slice first, `DW` bits per beat, under a valid/ready handshake. It generalises the fixed two-channel, 4-beat, no-backpressure arbiter to N channels, arbitrary bus width and downstream stall support.

## Interface
- `NREQ`, 2: number of requesters (≥2).
- `ADDRW`, 24: address width; word width `WORDW = ADDRW+8`.
- `DW`, 8: bus width; `WORDW % DW == 0` required; `BEATS = WORDW/DW`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester bus request.
- `data_in`  in  NREQ*WORDW  flattened words; requester i at `[i*WORDW +: WORDW]`.
- `grant`  out  NREQ  one-hot grant, registered.
- `data_out`  out  DW  current beat.
- `data_valid`  out  1  beat on `data_out` valid.
- `data_ready`  in  1  downstream accepts beat when high with `data_valid`.
- `data_last`  out  1  high with final beat of a word.

## Operation
- States: IDLE (`grant`=0, `data_valid`=0) and SEND (`grant` one-hot, `data_valid`=1).
- Arbitration is round-robin from pointer `last_idx`: search order `last_idx+1, last_idx+2, …` modulo NREQ; first asserted `req` wins.
- IDLE, any `req` high: register winner's grant, beat counter=0, go SEND.
- SEND: `data_out = data_in[granted][beat*DW +: DW]`, mux driven by registered grant/beat. Beat advances only on `data_valid && data_ready`.
- `data_last` = (beat == BEATS-1) in SEND.
- Last beat accepted: `last_idx` ← granted index. Re-arbitrate same cycle over current `req` using the updated pointer:
  - If a winner exists, grant it next cycle with no idle bubble (the just-served requester ranks last).
  - Otherwise go IDLE.
- Requester contract: hold `req` high and `data_in` slice stable while granted. `req` dropping mid-word is ignored; the word completes.
- `data_ready` low: `data_out`, `data_last`, `grant` and beat are held. No timeout.
- Counter width `$clog2(BEATS)` (minimum 1); it never wraps past BEATS-1.

## Timing
- Reset values: `grant`=0, `data_valid`=0, `data_last`=0, `data_out`=0, beat=0, `last_idx`=NREQ-1 (so requester 0 has first priority).
- Reset asserted mid-word aborts immediately. No partial state survives.
- Grant latency: `req` seen in IDLE at edge t → `grant`/`data_valid` high after edge t.
- With `data_ready` held high, a word occupies exactly BEATS cycles.
- Back-to-back words across requesters need BEATS cycles each, zero gap.
- Simultaneous requests are resolved purely by the round-robin pointer. No fixed priority except the post-reset order.

## Configuration
- `BUS_ARBITER_LOCK_EN` defined: adds input `req_lock` [NREQ]. If the granted requester has `req_lock` and `req` high on its last accepted beat, it keeps the grant for another word (beat→0, `last_idx` unchanged) regardless of other requests. Used for multi-word SHA/AES bursts.
- Undefined: no `req_lock` port; every word ends with re-arbitration as described above.

## Test plan
- Reset, NREQ=2, DW=8: assert `req`=01, `data_in[31:0]`=0xA1B2C3D4, ready high → grant=01 one cycle later; `data_out` D4,C3,B2,A1 on consecutive cycles; `data_last` on A1; then IDLE.
- `req`=11 held continuously → grants alternate 01,10,01,… every 4 cycles, no idle cycle between words.
- NREQ=4, `req`=1111 from reset → grant order 0,1,2,3,0. Drop `req[1]` → order skips 1.
- Stall: toggle `data_ready` 1,0,0,1,1,1 → exactly 4 accepted beats. `data_out` stable during stalls. `data_last` only on the 4th accepted beat.
- ADDRW=24, DW=16 → 2 beats per word, 0xC3D4 then 0xA1B2. Assert `rst_n` low on beat 1 → all outputs 0 next edge; after reset release, requester 0 is granted first.
- With `BUS_ARBITER_LOCK_EN`, `req`=11, `req_lock`=01 → requester 0 keeps the grant for consecutive words until `req_lock[0]` falls, then requester 1 is granted.
